neuron_lif: RTL and testbench



---
 rtl/neuron_pkg.sv | 21 ++
 rtl/lif_update.sv | 42 ++++
 rtl/neuron_lif.sv | 123 ++++++++++++
 tb/tb_neuron_lif.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared types and sizing helpers for the neuron cell: the weighted-sum neuron
// upstream and the leaky integrate-and-fire stage (neuron_lif).
//   lif_state_t : IDLE (accepting sums) / REFRACT (refractory, not accepting)
//   i_size()    : width of the weighted sum, 2*n_size + b_size/2
// -----------------------------------------------------------------------------
package neuron_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        REFRACT = 1'b1
    } lif_state_t;

    // Weighted-sum width: full product width plus headroom for accumulating
    // b_size products.
    function automatic int i_size(input int n_size, input int b_size);
        return 2 * n_size + b_size / 2;
    endfunction

endpackage

// File: rtl/lif_update.sv
// -----------------------------------------------------------------------------
// lif_update
// Combinational membrane-potential update for the LIF stage.
//   potential : current membrane potential
//   sum_in    : incoming weighted sum (only added when accept is high)
//   threshold : firing threshold
//   accept    : a sum is consumed this cycle
//   leak_tick : apply one leak step (potential >> LEAK_SHIFT)
//   v_next    : potential - leak + sum, saturated to all-ones on overflow
//   fire      : accept && v_next >= threshold
// -----------------------------------------------------------------------------
module lif_update #(
    parameter int I_SIZE     = 80,
    parameter int LEAK_SHIFT = 4
) (
    input  logic [I_SIZE-1:0] potential,
    input  logic [I_SIZE-1:0] sum_in,
    input  logic [I_SIZE-1:0] threshold,
    input  logic              accept,
    input  logic              leak_tick,
    output logic [I_SIZE-1:0] v_next,
    output logic              fire
);

    logic [I_SIZE-1:0] leak_amt;
    logic [I_SIZE-1:0] leaked;
    logic [I_SIZE-1:0] add_amt;
    logic [I_SIZE:0]   sum_wide;

    always_comb begin
        leak_amt = leak_tick ? (potential >> LEAK_SHIFT) : '0;
        // leak_amt <= potential because LEAK_SHIFT >= 1, so this never underflows.
        leaked   = potential - leak_amt;
        add_amt  = accept ? sum_in : '0;
        // One extra bit catches the carry so the potential clamps instead of wrapping.
        sum_wide = {1'b0, leaked} + {1'b0, add_amt};
        v_next   = sum_wide[I_SIZE] ? '1 : sum_wide[I_SIZE-1:0];
        // Leak-only cycles can never fire.
        fire     = accept && (v_next >= threshold);
    end

endmodule

// File: rtl/neuron_lif.sv
// -----------------------------------------------------------------------------
// neuron_lif
// Leaky integrate-and-fire stage fed by the weighted-sum neuron. Each accepted
// sum is added to the membrane potential (with an optional leak step in the
// same update); reaching the threshold emits a one-cycle spike, clears the
// potential and enters a refractory period of REFRAC_CYCLES cycles.
//
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   sum_valid    : sum_in is valid
//   sum_ready    : registered; high exactly while in IDLE (and out of reset)
//   sum_in       : unsigned weighted sum
//   threshold    : unsigned firing threshold, sampled on each update edge
//   leak_tick    : apply one leak step this cycle (ignored in REFRACT)
//   spike        : registered one-cycle spike pulse
//   potential    : registered membrane potential
//   spike_count  : spikes since reset, wraps modulo 2^CNT_SIZE
//   state        : debug view of the FSM state
//
// Handshake: a sum is transferred on a rising edge where sum_valid && sum_ready.
// sum_valid must not depend on sum_ready; once raised, sum_valid and sum_in
// stay stable until the transfer edge. While sum_ready is low nothing is
// consumed.
// -----------------------------------------------------------------------------
module neuron_lif
    import neuron_pkg::*;
#(
    parameter int N_SIZE        = 32,
    parameter int B_SIZE        = 32,
    parameter int I_SIZE        = i_size(N_SIZE, B_SIZE),
    parameter int LEAK_SHIFT    = 4,
    parameter int REFRAC_CYCLES = 3,
    parameter int CNT_SIZE      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sum_valid,
    output logic                sum_ready,
    input  logic [I_SIZE-1:0]   sum_in,
    input  logic [I_SIZE-1:0]   threshold,
    input  logic                leak_tick,
    output logic                spike,
    output logic [I_SIZE-1:0]   potential,
    output logic [CNT_SIZE-1:0] spike_count,
    output lif_state_t          state
);

    localparam int REFRAC_W = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
    // Counter load value; the counter counts down to 0 and the cycle it is 0
    // is the last refractory cycle.
    localparam logic [REFRAC_W-1:0] REFRAC_LOAD =
        (REFRAC_CYCLES > 0) ? REFRAC_W'(REFRAC_CYCLES - 1) : '0;

    logic [REFRAC_W-1:0] refrac_cnt;
    logic                accept;
    logic [I_SIZE-1:0]   v_next;
    logic                fire;

    // sum_ready is only ever high in IDLE, so it alone qualifies the transfer.
    assign accept = sum_valid && sum_ready;

    lif_update #(
        .I_SIZE     (I_SIZE),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .potential (potential),
        .sum_in    (sum_in),
        .threshold (threshold),
        .accept    (accept),
        .leak_tick (leak_tick),
        .v_next    (v_next),
        .fire      (fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            refrac_cnt  <= '0;
            potential   <= '0;
            spike       <= 1'b0;
            spike_count <= '0;
            sum_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        spike       <= 1'b1;
                        potential   <= '0;
                        spike_count <= spike_count + CNT_SIZE'(1);
                        if (REFRAC_CYCLES > 0) begin
                            state      <= REFRACT;
                            refrac_cnt <= REFRAC_LOAD;
                            sum_ready  <= 1'b0;
                        end else begin
                            sum_ready  <= 1'b1;
                        end
                    end else begin
                        spike     <= 1'b0;
                        potential <= v_next;
                        sum_ready <= 1'b1;
                    end
                end
                REFRACT: begin
                    spike     <= 1'b0;
                    potential <= '0;
                    if (refrac_cnt == '0) begin
                        state     <= IDLE;
                        sum_ready <= 1'b1;
                    end else begin
                        refrac_cnt <= refrac_cnt - REFRAC_W'(1);
                        sum_ready  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    spike     <= 1'b0;
                    sum_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_lif.sv
// -----------------------------------------------------------------------------
// tb_neuron_lif
// Directed bench for neuron_lif. u_a uses the default configuration
// (LEAK_SHIFT=4, REFRAC_CYCLES=3, CNT_SIZE=16); u_b uses REFRAC_CYCLES=0 and
// CNT_SIZE=4 for the wrap / back-to-back case. Drivers push the expected
// registered outputs for the following cycle into a queue; a monitor on the
// falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_neuron_lif;
    import neuron_pkg::*;

    localparam int I_SIZE = 80;
    localparam int CW     = 16;
    localparam int EXP_W  = 2 + I_SIZE + CW;
    localparam logic [I_SIZE-1:0] ALL1 = '1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (default parameters) ----------------
    logic              a_valid, a_ready, a_leak, a_spike;
    logic [I_SIZE-1:0] a_sum, a_thr, a_pot;
    logic [CW-1:0]     a_cnt;
    lif_state_t        a_state;

    neuron_lif u_a (
        .clk         (clk),
        .rst         (rst),
        .sum_valid   (a_valid),
        .sum_ready   (a_ready),
        .sum_in      (a_sum),
        .threshold   (a_thr),
        .leak_tick   (a_leak),
        .spike       (a_spike),
        .potential   (a_pot),
        .spike_count (a_cnt),
        .state       (a_state)
    );

    // ---------------- DUT B (no refractory, 4-bit counter) ----------------
    logic              b_valid, b_ready, b_leak, b_spike;
    logic [I_SIZE-1:0] b_sum, b_thr, b_pot;
    logic [3:0]        b_cnt;
    lif_state_t        b_state;

    neuron_lif #(
        .REFRAC_CYCLES (0),
        .CNT_SIZE      (4)
    ) u_b (
        .clk         (clk),
        .rst         (rst),
        .sum_valid   (b_valid),
        .sum_ready   (b_ready),
        .sum_in      (b_sum),
        .threshold   (b_thr),
        .leak_tick   (b_leak),
        .spike       (b_spike),
        .potential   (b_pot),
        .spike_count (b_cnt),
        .state       (b_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_a_q[$];
    logic [EXP_W-1:0] exp_b_q[$];
    int               tag_a_q[$];
    int               tag_b_q[$];

    task automatic check(input string name, input logic [I_SIZE-1:0] act,
                         input logic [I_SIZE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [EXP_W-1:0] e;
        while (tag_a_q.size() > 0 && tag_a_q[0] <= cyc) begin
            void'(tag_a_q.pop_front());
            e = exp_a_q.pop_front();
            check("a_ready", I_SIZE'(a_ready), I_SIZE'(e[EXP_W-1]));
            check("a_spike", I_SIZE'(a_spike), I_SIZE'(e[EXP_W-2]));
            check("a_potential", a_pot, e[CW +: I_SIZE]);
            check("a_spike_count", I_SIZE'(a_cnt), I_SIZE'(e[CW-1:0]));
        end
        while (tag_b_q.size() > 0 && tag_b_q[0] <= cyc) begin
            void'(tag_b_q.pop_front());
            e = exp_b_q.pop_front();
            check("b_ready", I_SIZE'(b_ready), I_SIZE'(e[EXP_W-1]));
            check("b_spike", I_SIZE'(b_spike), I_SIZE'(e[EXP_W-2]));
            check("b_potential", b_pot, e[CW +: I_SIZE]);
            check("b_spike_count", I_SIZE'(b_cnt), I_SIZE'(e[CW-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs and record what the outputs must be after the
    // next rising edge.
    task automatic step_a(input logic v, input logic [I_SIZE-1:0] s, input logic lk,
                          input logic e_rdy, input logic e_spk,
                          input logic [I_SIZE-1:0] e_pot, input logic [CW-1:0] e_cnt);
        a_valid = v;
        a_sum   = s;
        a_leak  = lk;
        exp_a_q.push_back({e_rdy, e_spk, e_pot, e_cnt});
        tag_a_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic [I_SIZE-1:0] s, input logic lk,
                          input logic e_rdy, input logic e_spk,
                          input logic [I_SIZE-1:0] e_pot, input logic [CW-1:0] e_cnt);
        b_valid = v;
        b_sum   = s;
        b_leak  = lk;
        exp_b_q.push_back({e_rdy, e_spk, e_pot, e_cnt});
        tag_b_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain();
        for (int i = 0; i < 20 && (tag_a_q.size() > 0 || tag_b_q.size() > 0); i++) begin
            @(negedge clk);
            #1;
        end
        if (tag_a_q.size() > 0 || tag_b_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", tag_a_q.size() + tag_b_q.size());
            tag_a_q.delete();
            exp_a_q.delete();
            tag_b_q.delete();
            exp_b_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_potential"}, a_pot, '0);
        check({tag, "_spike"}, I_SIZE'(a_spike), '0);
        check({tag, "_count"}, I_SIZE'(a_cnt), '0);
        check({tag, "_ready"}, I_SIZE'(a_ready), '0);
        check({tag, "_state"}, I_SIZE'(a_state), I_SIZE'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_sum = '0; a_thr = I_SIZE'(1000); a_leak = 1'b0;
        b_valid = 1'b0; b_sum = '0; b_thr = '0;             b_leak = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", I_SIZE'(a_ready), '0);

        // First edge after release raises sum_ready.
        step_a(0, '0, 0, 1, 0, '0, 0);

        // Integrate with leak on each accept: 400, 775, 1127 -> fire.
        step_a(1, I_SIZE'(400), 1, 1, 0, I_SIZE'(400), 0);
        step_a(1, I_SIZE'(400), 1, 1, 0, I_SIZE'(775), 0);
        step_a(1, I_SIZE'(400), 1, 0, 1, '0, 1);

        // Refractory backpressure: 50 held, ready low for 3 cycles, then accepted.
        step_a(1, I_SIZE'(50), 1, 0, 0, '0, 1);
        step_a(1, I_SIZE'(50), 1, 0, 0, '0, 1);
        step_a(1, I_SIZE'(50), 1, 1, 0, '0, 1);
        step_a(1, I_SIZE'(50), 0, 1, 0, I_SIZE'(50), 1);

        // Leak only: 160 -> 150; with threshold 0, 150 -> 141 and no spike.
        step_a(1, I_SIZE'(110), 0, 1, 0, I_SIZE'(160), 1);
        step_a(0, '0, 1, 1, 0, I_SIZE'(150), 1);
        a_thr = '0;
        step_a(0, '0, 1, 1, 0, I_SIZE'(141), 1);
        drain();

        // Asynchronous reset with nonzero potential and count.
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_idle");
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_thr = I_SIZE'(1000);
        step_a(1, I_SIZE'(15), 0, 1, 0, '0, 0);
        step_a(1, I_SIZE'(15), 0, 1, 0, I_SIZE'(15), 0);
        // Small potential: 15 >> 4 = 0, so leak leaves it at 15; threshold 0 still no fire.
        a_thr = '0;
        step_a(0, '0, 1, 1, 0, I_SIZE'(15), 0);
        // Accept together with leak: single step each time.
        a_thr = I_SIZE'(1000);
        step_a(1, I_SIZE'(160), 1, 1, 0, I_SIZE'(175), 0);
        step_a(1, I_SIZE'(25), 1, 1, 0, I_SIZE'(190), 0);
        // threshold 0 fires on any accept.
        a_thr = '0;
        step_a(1, I_SIZE'(5), 0, 0, 1, '0, 1);
        drain();

        // Asynchronous reset in the middle of REFRACT, while spike is high.
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_refract");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Saturation: all-ones-1, then all-ones carries and clamps, firing at threshold all-ones.
        a_thr = ALL1;
        step_a(0, '0, 0, 1, 0, '0, 0);
        step_a(1, ALL1 - I_SIZE'(1), 0, 1, 0, ALL1 - I_SIZE'(1), 0);
        step_a(1, ALL1, 0, 0, 1, '0, 1);
        step_a(0, '0, 0, 0, 0, '0, 1);
        step_a(0, '0, 0, 0, 0, '0, 1);
        step_a(0, '0, 0, 1, 0, '0, 1);
        drain();

        // No refractory, 4-bit counter: 16 back-to-back firing accepts wrap to 0.
        b_thr = '0;
        for (int i = 0; i < 16; i++) begin
            step_b(1, I_SIZE'(i + 1), 0, 1, 1, '0, CW'((i + 1) % 16));
        end
        step_b(0, '0, 0, 1, 0, '0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
